// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the target-count sequencer.
// State encoding plus the up/down/hold command codes sent to up_counter.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] CNT_UP   = 2'b10;
  localparam logic [1:0] CNT_DN   = 2'b01;
  localparam logic [1:0] CNT_HOLD = 2'b00;

  localparam logic [7:0] STEPS_SAT = 8'hff;

  // Saturating step-counter increment.
  function automatic logic [7:0] steps_inc(
    input logic [7:0] s
  );
    if (s == STEPS_SAT) begin
      return s;
    end
    return s + 8'd1;
  endfunction

endpackage

// File: rtl/counter_target_seq.sv
// Drives an external up_counter toward a captured target, one step at a time.
// Ports: clk, rst (async low), start, abort, target, cnt in; cnt_ent, busy, done, err, steps out.
module counter_target_seq
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int MAX_STEPS = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt,
  output logic [1:0]       cnt_ent,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       steps
);

  localparam logic [7:0] MAX_Q = 8'(MAX_STEPS);

  state_e           state_q;
  logic [WIDTH-1:0] target_q;
  logic [1:0]       cnt_ent_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [7:0]       steps_q;
  logic [7:0]       steps_d;
  logic [1:0]       dir_d;

  always_comb begin
    steps_d = steps_inc(steps_q);
    dir_d   = (cnt < target_q) ? CNT_UP : CNT_DN;
  end

  // Each step is STEP then EVAL, so the counter has
  // settled before every compare and never overshoots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      cnt_ent_q <= CNT_HOLD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      steps_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_ent_q <= CNT_HOLD;
          done_q    <= 1'b0;
          if (start && !abort) begin
            target_q <= target;
            steps_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= EVAL;
          end
        end
        EVAL: begin
          if (abort) begin
            cnt_ent_q <= CNT_HOLD;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (cnt == target_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (steps_q == MAX_Q) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_ent_q <= dir_d;
            steps_q   <= steps_d;
            state_q   <= STEP;
          end
        end
        STEP: begin
          cnt_ent_q <= CNT_HOLD;
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= EVAL;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          cnt_ent_q <= CNT_HOLD;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign cnt_ent = cnt_ent_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign steps   = steps_q;

endmodule

// File: tb/tb_counter_target_seq.sv
// Bench for counter_target_seq: two instances (default and 4-step budget)
// each closing the loop through a behavioural up_counter.
module tb_counter_target_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [5:0] target;
  logic [5:0] cnt_a, cnt_b;
  logic [1:0] ent_a, ent_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;
  logic       err_a, err_b;
  logic [7:0] steps_a, steps_b;
  logic       ld;
  logic [5:0] ld_val;

  int unsigned vec  = 0;
  int unsigned miss = 0;

  always #5 clk = ~clk;

  counter_target_seq #(.WIDTH(6), .MAX_STEPS(100)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .target(target), .cnt(cnt_a), .cnt_ent(ent_a),
    .busy(busy_a), .done(done_a), .err(err_a), .steps(steps_a)
  );

  counter_target_seq #(.WIDTH(6), .MAX_STEPS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .target(target), .cnt(cnt_b), .cnt_ent(ent_b),
    .busy(busy_b), .done(done_b), .err(err_b), .steps(steps_b)
  );

  // up_counter stand-ins; ld lets the bench jam a value.
  always @(posedge clk) begin
    if (ld) begin
      cnt_a <= ld_val;
      cnt_b <= ld_val;
    end else begin
      if (ent_a == 2'b10) cnt_a <= cnt_a + 6'd1;
      else if (ent_a == 2'b01) cnt_a <= cnt_a - 6'd1;
      if (ent_b == 2'b10) cnt_b <= cnt_b + 6'd1;
      else if (ent_b == 2'b01) cnt_b <= cnt_b - 6'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int v);
    @(negedge clk);
    ld = 1'b1;
    ld_val = 6'(v);
    @(negedge clk);
    ld = 1'b0;
  endtask

  // One run on both instances; expectations from distance arithmetic.
  task automatic run(input int c0, input int t);
    int d, nb, k, dpa, dpb, ka, pa, pb, bada, badb;
    logic [1:0] dir;
    d = (t > c0) ? t - c0 : c0 - t;
    nb = (d < 4) ? d : 4;
    dir = (t > c0) ? 2'b10 : 2'b01;
    dpa = 0; dpb = 0; ka = -1; pa = 0; pb = 0;
    bada = 0; badb = 0; k = 0;
    load(c0);
    target = 6'(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    target = 6'($urandom);
    chk("busy_after_start", {busy_a, busy_b}, 2'b11);
    chk("err_cleared", {err_a, err_b}, 2'b00);
    while ((busy_a || busy_b) && k < 300) begin
      if (done_a) begin dpa++; ka = k; end
      if (done_b) dpb++;
      if (ent_a != 2'b00) begin pa++; if (ent_a != dir) bada++; end
      if (ent_b != 2'b00) begin pb++; if (ent_b != dir) badb++; end
      @(negedge clk);
      k++;
    end
    chk("run_bounded", 32'(k < 300), 1);
    chk("a_done_pulses", dpa, 1);
    chk("a_done_latency", ka, 2 * d + 1);
    chk("a_steps", steps_a, d);
    chk("a_cmds", pa, d);
    chk("a_dir", bada, 0);
    chk("a_cnt", cnt_a, t);
    chk("a_err", err_a, 0);
    chk("b_done_pulses", dpb, (d <= 4) ? 1 : 0);
    chk("b_steps", steps_b, nb);
    chk("b_cmds", pb, nb);
    chk("b_dir", badb, 0);
    chk("b_cnt", cnt_b, (t > c0) ? c0 + nb : c0 - nb);
    chk("b_err", err_b, (d <= 4) ? 0 : 1);
  endtask

  initial begin
    int k, dp, c0, t;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    target = '0; ld = 1'b0; ld_val = '0;
    #1;
    chk("rst_ent", ent_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_steps", steps_a, 0);
    load(0);
    rst = 1'b1;

    run(0, 5);
    run(20, 17);
    run(9, 9);
    run(0, 10);
    run(3, 6);

    // Abort after two steps; a start mid-run must be ignored.
    load(0);
    target = 6'd30;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    target = 6'd0;
    @(negedge clk);
    start = 1'b0;
    k = 0; dp = 0;
    while (!(steps_a == 8'd2 && ent_a == 2'b00) && k < 20) begin
      if (done_a) dp++;
      @(negedge clk);
      k++;
    end
    chk("abort_reach", 32'(k < 20), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ent", ent_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_steps", steps_a, 2);
    chk("abort_cnt", cnt_a, 2);
    chk("abort_err", err_a, 0);
    chk("abort_no_done", dp + 32'(done_a), 0);
    @(negedge clk);
    chk("abort_stays_idle", busy_a, 0);

    // abort wins over start in IDLE
    abort = 1'b1;
    start = 1'b1;
    target = 6'd3;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_busy", busy_a, 0);
    chk("abort_start_steps", steps_a, 2);

    // Counter jammed mid-run; sequencer re-aims each EVAL.
    load(10);
    target = 6'd40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(steps_a == 8'd3 && ent_a == 2'b00) && k < 20) begin
      @(negedge clk);
      k++;
    end
    ld = 1'b1;
    ld_val = 6'd50;
    @(negedge clk);
    ld = 1'b0;
    k = 0; dp = 0;
    while (busy_a && k < 300) begin
      if (done_a) dp++;
      @(negedge clk);
      k++;
    end
    chk("jam_bounded", 32'(k < 300), 1);
    chk("jam_done", dp, 1);
    chk("jam_cnt", cnt_a, 40);
    chk("jam_err", err_a, 0);

    // Async reset while in STEP.
    load(0);
    target = 6'd40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (ent_a != 2'b10 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("step_reach", ent_a, 2'b10);
    rst = 1'b0;
    #1;
    chk("arst_ent", ent_a, 0);
    chk("arst_busy", {busy_a, busy_b}, 0);
    chk("arst_steps", steps_a, 0);
    chk("arst_done", done_a, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_idle", busy_a, 0);

    for (int i = 0; i < 20; i++) begin
      c0 = int'($urandom_range(0, 63));
      if ($urandom_range(0, 4) == 0) t = c0;
      else t = int'($urandom_range(0, 63));
      run(c0, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
